layer_sequencer: RTL and testbench

//  Parametrised layer scheduler for the accelerator top. Runs a programmable list of up to MAX_STEPS steps.

---
 rtl/lenet_pkg.sv | 29 ++
 rtl/seq_port_mux.sv | 57 +++++
 rtl/layer_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_layer_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// lenet_pkg
//   Shared definitions for the layer sequencer:
//   - default widths used as parameter defaults,
//   - sequencer state encodings,
//   - a saturating 32-bit increment helper for the performance counters.
package lenet_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 18;
  localparam int DEF_NUM_ENG    = 4;
  localparam int DEF_MAX_STEPS  = 8;
  localparam int DEF_IDX_W      = 4;

  typedef logic [DEF_IDX_W-1:0] eng_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DONE = 3'd6,
    ST_ERR  = 3'd7
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/seq_port_mux.sv
// seq_port_mux
//   NUM_ENG-way selector of engine DRAM ports onto the shared DRAM port.
//   When i_en is low, or i_sel does not name an attached engine, every
//   output is driven to zero.
// Ports
//   i_en        forward enable (sequencer in RUN)
//   i_sel       selected engine index
//   i_data      flattened engine write data, engine k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_addr_in   flattened engine read addresses
//   i_addr_out  flattened engine write addresses
//   i_wr/i_rd   per-engine DRAM write/read enables
//   o_data, o_addr_in, o_addr_out, o_wr, o_rd   muxed DRAM signals
module seq_port_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int NUM_ENG    = 4,
  parameter int IDX_W      = 4
) (
  input  logic                          i_en,
  input  logic [IDX_W-1:0]              i_sel,
  input  logic [NUM_ENG*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_ENG*ADDR_WIDTH-1:0] i_addr_in,
  input  logic [NUM_ENG*ADDR_WIDTH-1:0] i_addr_out,
  input  logic [NUM_ENG-1:0]            i_wr,
  input  logic [NUM_ENG-1:0]            i_rd,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic [ADDR_WIDTH-1:0]         o_addr_in,
  output logic [ADDR_WIDTH-1:0]         o_addr_out,
  output logic                          o_wr,
  output logic                          o_rd
);

  // Select the addressed engine's port; zero when not forwarding.
  always_comb begin
    o_data     = '0;
    o_addr_in  = '0;
    o_addr_out = '0;
    o_wr       = 1'b0;
    o_rd       = 1'b0;
    if (i_en) begin
      for (int k = 0; k < NUM_ENG; k++) begin
        if (int'(i_sel) == k) begin
          o_data     = i_data[k*DATA_WIDTH +: DATA_WIDTH];
          o_addr_in  = i_addr_in[k*ADDR_WIDTH +: ADDR_WIDTH];
          o_addr_out = i_addr_out[k*ADDR_WIDTH +: ADDR_WIDTH];
          o_wr       = i_wr[k];
          o_rd       = i_rd[k];
        end else begin
          o_wr       = o_wr;
        end
      end
    end else begin
      o_data     = '0;
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer
//   Runs a snapshot of a programmable step list. Each step enables one
//   compute engine and forwards that engine's DRAM port to the shared DRAM
//   until the engine pulses done. Supports abort and flags steps that name
//   a non-existent engine.
// Optional feature macro: LAYER_SEQ_PERF_EN
//   defined   -> perf_total / perf_step cycle counters are built
//   undefined -> perf_total / perf_step are tied to zero
// Ports
//   clk, arst                clock, asynchronous active-high reset
//   start, abort             program start (IDLE only) / return to IDLE
//   rdy_data                 DRAM ready, registered once before use
//   cfg_num_steps, cfg_seq   program length and per-step engine index
//   eng_done                 per-engine completion pulses
//   eng_data_out, eng_addr_in, eng_addr_out, eng_wr, eng_rd   engine DRAM ports
//   eng_en                   one-hot engine enable
//   data_out, addr_in, addr_out, dram_en_wr, dram_en_rd       shared DRAM port
//   cur_step, busy, done, err                                 status
//   perf_total, perf_step                                     cycle counters
module layer_sequencer
  import lenet_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_ENG    = DEF_NUM_ENG,
  parameter int MAX_STEPS  = DEF_MAX_STEPS,
  parameter int IDX_W      = DEF_IDX_W
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          rdy_data,
  input  logic [IDX_W:0]                cfg_num_steps,
  input  logic [MAX_STEPS*IDX_W-1:0]    cfg_seq,
  input  logic [NUM_ENG-1:0]            eng_done,
  input  logic [NUM_ENG*DATA_WIDTH-1:0] eng_data_out,
  input  logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_in,
  input  logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_out,
  input  logic [NUM_ENG-1:0]            eng_wr,
  input  logic [NUM_ENG-1:0]            eng_rd,
  output logic [NUM_ENG-1:0]            eng_en,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic [ADDR_WIDTH-1:0]         addr_in,
  output logic [ADDR_WIDTH-1:0]         addr_out,
  output logic                          dram_en_wr,
  output logic                          dram_en_rd,
  output logic [IDX_W-1:0]              cur_step,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [31:0]                   perf_total,
  output logic [31:0]                   perf_step
);

  state_t                     r_state;
  logic [IDX_W-1:0]           r_step;
  logic [IDX_W:0]             r_num_steps;
  logic [MAX_STEPS*IDX_W-1:0] r_seq;
  logic [IDX_W-1:0]           r_cur_eng;
  logic                       r_rdy_data_ff;
  logic                       r_done;
  logic                       r_err;

  logic [IDX_W-1:0]           w_fetch;
  logic [NUM_ENG-1:0]         w_onehot;
  logic                       w_sel_done;
  logic                       w_eng_bad;
  logic                       w_last;
  logic [IDX_W:0]             w_num_clamp;
  logic                       w_run;

  assign w_run       = (r_state == ST_RUN);
  assign w_num_clamp = (int'(cfg_num_steps) > MAX_STEPS) ? (IDX_W+1)'(MAX_STEPS) : cfg_num_steps;
  assign w_eng_bad   = (int'(w_fetch) >= NUM_ENG);
  assign w_last      = (({1'b0, r_step} + (IDX_W+1)'(1)) == r_num_steps);
  // Only the running engine's done pulse can advance the program.
  assign w_sel_done  = |(eng_done & w_onehot);

  // Engine index of the current step from the snapshot list.
  always_comb begin
    w_fetch = '0;
    for (int k = 0; k < MAX_STEPS; k++) begin
      w_fetch = (int'(r_step) == k) ? r_seq[k*IDX_W +: IDX_W] : w_fetch;
    end
  end

  // One-hot decode of the registered engine index.
  always_comb begin
    w_onehot = '0;
    for (int k = 0; k < NUM_ENG; k++) begin
      w_onehot[k] = (int'(r_cur_eng) == k);
    end
  end

  // Sequencer FSM: snapshot, per-step load/run, completion and error pulses.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state       <= ST_IDLE;
      r_step        <= '0;
      r_num_steps   <= '0;
      r_seq         <= '0;
      r_cur_eng     <= '0;
      r_rdy_data_ff <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_rdy_data_ff <= rdy_data;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      if (abort && (r_state != ST_IDLE)) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_num_steps <= w_num_clamp;
              r_seq       <= cfg_seq;
              r_step      <= '0;
              if (cfg_num_steps == '0) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_LOAD;
              end
            end
          end
          ST_LOAD: begin
            r_cur_eng <= w_fetch;
            if (w_eng_bad) begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (w_sel_done) begin
              r_step <= r_step + IDX_W'(1);
              if (w_last) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_LOAD;
              end
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          ST_ERR:  r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Enable follows the registered DRAM ready while the step runs.
  assign eng_en   = (w_run && r_rdy_data_ff) ? w_onehot : '0;
  assign cur_step = r_step;
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign err      = r_err;

  seq_port_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_ENG    (NUM_ENG),
    .IDX_W      (IDX_W)
  ) u_port_mux (
    .i_en       (w_run),
    .i_sel      (r_cur_eng),
    .i_data     (eng_data_out),
    .i_addr_in  (eng_addr_in),
    .i_addr_out (eng_addr_out),
    .i_wr       (eng_wr),
    .i_rd       (eng_rd),
    .o_data     (data_out),
    .o_addr_in  (addr_in),
    .o_addr_out (addr_out),
    .o_wr       (dram_en_wr),
    .o_rd       (dram_en_rd)
  );

`ifdef LAYER_SEQ_PERF_EN
  logic [31:0] r_perf_total;
  logic [31:0] r_perf_step;
  logic [31:0] r_step_cyc;

  // RUN-cycle counters; the step count includes the cycle carrying eng_done.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_perf_total <= 32'd0;
      r_perf_step  <= 32'd0;
      r_step_cyc   <= 32'd0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_perf_total <= 32'd0;
      r_step_cyc   <= 32'd0;
    end else if (r_state == ST_LOAD) begin
      r_step_cyc   <= 32'd0;
    end else if (w_run) begin
      r_perf_total <= sat_inc(r_perf_total);
      r_step_cyc   <= sat_inc(r_step_cyc);
      if (w_sel_done && !abort) begin
        r_perf_step <= sat_inc(r_step_cyc);
      end
    end
  end

  assign perf_total = r_perf_total;
  assign perf_step  = r_perf_step;
`else
  assign perf_total = 32'd0;
  assign perf_step  = 32'd0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer
//   Directed bench for layer_sequencer (NUM_ENG=4, MAX_STEPS=8). Inputs are
//   driven 1 time unit after the rising edge; outputs are checked there too.
module tb_layer_sequencer;

  localparam int DW = 32;
  localparam int AW = 18;
  localparam int NE = 4;
  localparam int MS = 8;
  localparam int IW = 4;

`ifdef LAYER_SEQ_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              arst;
  logic              start;
  logic              abort;
  logic              rdy_data;
  logic [IW:0]       cfg_num_steps;
  logic [MS*IW-1:0]  cfg_seq;
  logic [NE-1:0]     eng_done;
  logic [NE*DW-1:0]  eng_data_out;
  logic [NE*AW-1:0]  eng_addr_in;
  logic [NE*AW-1:0]  eng_addr_out;
  logic [NE-1:0]     eng_wr;
  logic [NE-1:0]     eng_rd;
  logic [NE-1:0]     eng_en;
  logic [DW-1:0]     data_out;
  logic [AW-1:0]     addr_in;
  logic [AW-1:0]     addr_out;
  logic              dram_en_wr;
  logic              dram_en_rd;
  logic [IW-1:0]     cur_step;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       perf_total;
  logic [31:0]       perf_step;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int d0;
  int e0;

  layer_sequencer #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .NUM_ENG (NE), .MAX_STEPS (MS), .IDX_W (IW)
  ) dut (
    .clk (clk), .arst (arst), .start (start), .abort (abort), .rdy_data (rdy_data),
    .cfg_num_steps (cfg_num_steps), .cfg_seq (cfg_seq), .eng_done (eng_done),
    .eng_data_out (eng_data_out), .eng_addr_in (eng_addr_in), .eng_addr_out (eng_addr_out),
    .eng_wr (eng_wr), .eng_rd (eng_rd), .eng_en (eng_en), .data_out (data_out),
    .addr_in (addr_in), .addr_out (addr_out), .dram_en_wr (dram_en_wr),
    .dram_en_rd (dram_en_rd), .cur_step (cur_step), .busy (busy), .done (done),
    .err (err), .perf_total (perf_total), .perf_step (perf_step)
  );

  always #5 clk = ~clk;

  // Count pulses mid-cycle so each one-cycle pulse is seen exactly once.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err)  err_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_step(input int k, input int e);
    cfg_seq[k*IW +: IW] = IW'(e);
  endtask

  // Pulse start; returns in the cycle after start was sampled.
  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called in the first RUN cycle of a step; eng_done arrives in RUN cycle 'cyc'.
  task automatic run_step(input int eng, input int cyc);
    logic [NE-1:0] oh;
    oh      = '0;
    oh[eng] = 1'b1;
    check("run_en", eng_en, oh);
    repeat (cyc - 1) tick();
    eng_done = oh;
    tick();
    eng_done = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    arst = 1'b1; start = 1'b0; abort = 1'b0; rdy_data = 1'b1;
    cfg_num_steps = '0; cfg_seq = '0; eng_done = '0;
    for (int k = 0; k < NE; k++) begin
      eng_data_out[k*DW +: DW] = 32'hA000_0000 + DW'(k);
      eng_addr_in[k*AW +: AW]  = 18'h00100 + AW'(k);
      eng_addr_out[k*AW +: AW] = 18'h00200 + AW'(k);
    end
    eng_wr = 4'b0101;
    eng_rd = 4'b1010;
    #12;
    check("rst_en", eng_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_step", cur_step, 0);
    check("rst_data", data_out, 0);
    check("rst_perf", perf_total, 0);
    arst = 1'b0;
    tick();
    tick();

    // T1: three steps of 10 RUN cycles; start/cfg changes while busy ignored
    cfg_seq = '0; set_step(0, 0); set_step(1, 1); set_step(2, 2); cfg_num_steps = 5'd3;
    d0 = done_cnt;
    kick();
    check("t1_load_busy", busy, 1);
    check("t1_load_en", eng_en, 0);
    check("t1_load_data", data_out, 0);
    tick();
    check("t1_cur0", cur_step, 0);
    check("t1_data0", data_out, 32'hA000_0000);
    check("t1_wr0", dram_en_wr, 1);
    check("t1_rd0", dram_en_rd, 0);
    start = 1'b1; cfg_num_steps = 5'd1; cfg_seq = {8{4'd3}};
    run_step(0, 10);
    start = 1'b0;
    check("t1_load1_en", eng_en, 0);
    tick();
    check("t1_cur1", cur_step, 1);
    check("t1_addr_in1", addr_in, 18'h00101);
    check("t1_addr_out1", addr_out, 18'h00201);
    check("t1_rd1", dram_en_rd, 1);
    check("t1_wr1", dram_en_wr, 0);
    run_step(1, 10);
    tick();
    check("t1_cur2", cur_step, 2);
    check("t1_data2", data_out, 32'hA000_0002);
    run_step(2, 10);
    check("t1_done", done, 1);
    check("t1_perf_total", perf_total, PERF_ON ? 32'd30 : 32'd0);
    check("t1_perf_step", perf_step, PERF_ON ? 32'd10 : 32'd0);
    tick();
    check("t1_done_clr", done, 0);
    check("t1_idle", busy, 0);
    check("t1_done_cnt", done_cnt - d0, 1);

    // T2: zero-length program
    cfg_num_steps = 5'd0;
    d0 = done_cnt;
    kick();
    check("t2_done", done, 1);
    check("t2_en", eng_en, 0);
    check("t2_perf_clr", perf_total, 0);
    tick();
    check("t2_idle", busy, 0);
    check("t2_done_cnt", done_cnt - d0, 1);

    // T3: second step names engine 5 -> err, no done
    cfg_seq = '0; set_step(0, 1); set_step(1, 5); cfg_num_steps = 5'd2;
    d0 = done_cnt; e0 = err_cnt;
    kick();
    tick();
    run_step(1, 3);
    check("t3_cur1", cur_step, 1);
    tick();
    check("t3_err", err, 1);
    check("t3_no_done", done, 0);
    check("t3_err_en", eng_en, 0);
    check("t3_perf_step", perf_step, PERF_ON ? 32'd3 : 32'd0);
    tick();
    check("t3_err_clr", err, 0);
    check("t3_idle", busy, 0);
    check("t3_err_cnt", err_cnt - e0, 1);
    check("t3_done_cnt", done_cnt - d0, 0);

    // Boundary: engine index equal to NUM_ENG is invalid
    cfg_seq = '0; set_step(0, 4); cfg_num_steps = 5'd1;
    kick();
    tick();
    check("bnd_err4", err, 1);
    tick();
    check("bnd_idle", busy, 0);

    // T4: abort beats eng_done of step 1; then a clean restart
    cfg_seq = '0; set_step(0, 0); set_step(1, 1); set_step(2, 2); cfg_num_steps = 5'd3;
    d0 = done_cnt;
    kick();
    tick();
    run_step(0, 2);
    tick();
    check("t4_en1", eng_en, 4'b0010);
    eng_done = 4'b0010; abort = 1'b1;
    tick();
    eng_done = '0; abort = 1'b0;
    check("t4_abort_idle", busy, 0);
    check("t4_abort_done", done, 0);
    check("t4_abort_data", data_out, 0);
    tick();
    check("t4_done_cnt", done_cnt - d0, 0);
    cfg_seq = '0; set_step(0, 2); cfg_num_steps = 5'd1;
    kick();
    tick();
    check("t4_restart_step", cur_step, 0);
    run_step(2, 4);
    check("t4_restart_done", done, 1);
    tick();

    // T5: rdy_data low gates eng_en; stray eng_done[2] ignored
    cfg_seq = '0; set_step(0, 0); cfg_num_steps = 5'd1;
    rdy_data = 1'b0;
    tick();
    kick();
    tick();
    check("t5_r1_en", eng_en, 0);
    tick();
    check("t5_r2_en", eng_en, 0);
    eng_done = 4'b0100;
    tick();
    eng_done = '0;
    check("t5_stray_busy", busy, 1);
    check("t5_stray_done", done, 0);
    check("t5_stray_step", cur_step, 0);
    check("t5_r3_en", eng_en, 0);
    tick();
    tick();
    check("t5_r5_en", eng_en, 0);
    rdy_data = 1'b1;
    check("t5_rise_en", eng_en, 0);
    tick();
    check("t5_r6_en", eng_en, 4'b0001);
    eng_done = 4'b0001;
    tick();
    eng_done = '0;
    check("t5_done", done, 1);
    check("t5_perf_step", perf_step, PERF_ON ? 32'd6 : 32'd0);
    check("t5_perf_total", perf_total, PERF_ON ? 32'd6 : 32'd0);
    tick();

    // Clamp: 15 steps requested, MAX_STEPS=8 run
    cfg_seq = '0; cfg_num_steps = 5'd15;
    d0 = done_cnt;
    kick();
    tick();
    for (int s = 0; s < MS; s++) begin
      check("clamp_step", cur_step, s);
      run_step(0, 1);
      if (s < MS - 1) begin
        check("clamp_no_done", done, 0);
        tick();
      end
    end
    check("clamp_done", done, 1);
    check("clamp_perf", perf_total, PERF_ON ? 32'd8 : 32'd0);
    tick();
    check("clamp_done_cnt", done_cnt - d0, 1);

    // T6: async reset mid-RUN
    cfg_seq = '0; set_step(0, 3); cfg_num_steps = 5'd1;
    kick();
    tick();
    check("t6_en3", eng_en, 4'b1000);
    check("t6_data3", data_out, 32'hA000_0003);
    check("t6_rd3", dram_en_rd, 1);
    #2 arst = 1'b1;
    #1;
    check("t6_rst_en", eng_en, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_data", data_out, 0);
    check("t6_rst_rd", dram_en_rd, 0);
    check("t6_rst_perf", perf_total, 0);
    #2 arst = 1'b0;
    tick();
    check("t6_idle_a", busy, 0);
    tick();
    check("t6_idle_b", busy, 0);
    check("t6_idle_en", eng_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
